// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Shares one sprite ROM between three requesters (fireboy, icegirl, gem/door sprites).
// A grant is computed combinationally each cycle, the granted address is driven to the
// ROM, and a valid/tag pair travels down a ROM_LAT-deep pipeline. It steers rom_data
// back to the right requester when the read data arrives.
//
// Build option: define SPRITE_ARB_ROUND_ROBIN_EN for round-robin arbitration. The search
// starts after the last granted index. Without it, arbitration is fixed priority 0 > 1 > 2.
//
// Ports:
//   Clk       system clock, all state on posedge
//   Reset     synchronous active-high reset
//   req       per-requester read request (held until granted)
//   addr0..2  per-requester read address
//   gnt       one-hot grant (combinational)
//   rom_addr  shared ROM address, 0 when idle
//   rom_rd    ROM read strobe (= |gnt)
//   rom_data  ROM read data, valid ROM_LAT cycles after rom_rd
//   rd_valid  one-hot return strobe, ROM_LAT cycles after the grant
//   rd_data   returned data (0 when rd_valid is 0)

module sprite_rom_arbiter #(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [2:0]        gnt,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_data,
    output logic [2:0]        rd_valid,
    output logic [DATA_W-1:0] rd_data
);

    logic [1:0] last_gnt;
    logic [1:0] last_gnt_next;
    logic [1:0] start_idx;
    logic [1:0] cand;
    logic [1:0] gnt_idx;
    logic       gnt_found;
    logic       gnt_ok;

    logic [ROM_LAT-1:0] pipe_vld;
    logic [1:0]         pipe_tag [ROM_LAT];

`ifdef SPRITE_ARB_ROUND_ROBIN_EN
    // Start one past the last winner, wrapping 2 -> 0.
    assign start_idx = (last_gnt == 2'd2) ? 2'd0 : last_gnt + 2'd1;
`else
    assign start_idx = 2'd0;
`endif

    // Circular search from start_idx; the first requesting index wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        cand      = start_idx;
        for (int k = 0; k < 3; k++) begin
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    assign gnt_ok = gnt_found && !Reset;
    assign gnt    = gnt_ok ? (3'b001 << gnt_idx) : 3'b000;
    assign rom_rd = gnt_ok;

    always_comb begin
        rom_addr = '0;
        if (gnt_ok) begin
            unique case (gnt_idx)
                2'd0:    rom_addr = addr0;
                2'd1:    rom_addr = addr1;
                default: rom_addr = addr2;
            endcase
        end
    end

    always_comb begin
        last_gnt_next = last_gnt;
        if (gnt_ok) begin
            last_gnt_next = gnt_idx;
        end
    end

    // Valid bits and the arbitration pointer are reset. In-flight reads are dropped.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_gnt <= 2'd2;
            pipe_vld <= '0;
        end else begin
            last_gnt    <= last_gnt_next;
            pipe_vld[0] <= gnt_ok;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    // Tags are qualified by pipe_vld, so they need no reset.
    always_ff @(posedge Clk) begin
        pipe_tag[0] <= gnt_idx;
        for (int i = 1; i < ROM_LAT; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    always_comb begin
        rd_valid = 3'b000;
        rd_data  = '0;
        if (pipe_vld[ROM_LAT-1] && !Reset) begin
            rd_valid = 3'b001 << pipe_tag[ROM_LAT-1];
            rd_data  = rom_data;
        end
    end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, sprite ROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, sprite palette-index width.
REQ-003 SHALL have parameter ROM_LAT, default 1, ROM read latency in cycles, legal range 1..4.
REQ-004 SHALL have port Clk  input  1  system clock; all state updates on posedge Clk.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  3  read request per requester: bit 0 fireboy, bit 1 icegirl, bit 2 gem/door sprites.
REQ-007 SHALL have ports addr0, addr1, addr2  input  ADDR_W  read address of each requester.
REQ-008 SHALL have port gnt  output  3  one-hot grant, at most one bit set.
REQ-009 SHALL have port rom_addr  output  ADDR_W  shared ROM address.
REQ-010 SHALL have port rom_rd  output  1  ROM read strobe.
REQ-011 SHALL have port rom_data  input  DATA_W  ROM read data, valid ROM_LAT cycles after rom_rd.
REQ-012 SHALL have port rd_valid  output  3  one-hot return strobe per requester.
REQ-013 SHALL have port rd_data  output  DATA_W  returned data, shared by all requesters.

Function
REQ-014 SHALL compute gnt combinationally in the same cycle from req and the registered priority pointer.
REQ-015 SHALL drive rom_addr with the address of the granted requester, and with 0 when no grant is active.
REQ-016 SHALL drive rom_rd = |gnt.
REQ-017 SHALL grant at most one request per cycle; a requester holds req and its address until it sees its gnt bit.
REQ-018 SHALL treat a requester that drops req before grant as withdrawn; no read is issued for it.
REQ-019 SHALL hold last_gnt, a 2-bit register (values 0..2), updated to the granted index on every grant cycle and unchanged otherwise.
REQ-020 SHALL carry, for each grant, a valid bit and a 2-bit requester tag through a ROM_LAT-deep shift pipeline.
REQ-021 SHALL assert rd_valid[i] for exactly one cycle, ROM_LAT cycles after the grant to i, with rd_data = rom_data in that cycle.
REQ-022 SHALL hold rd_valid = 0 and rd_data = 0 in cycles when no tag exits the pipeline.
REQ-023 SHALL sustain one grant per cycle under continuous requests with no bubbles, so back-to-back reads overlap in the pipeline.
REQ-024 SHALL return data strictly in grant order.
REQ-025 SHALL leave req bits for a requester that is not granted unchanged in cycles when another requester is granted.

Reset
REQ-026 SHALL, while Reset is high, force gnt = 0, rom_rd = 0, rom_addr = 0, rd_valid = 0, rd_data = 0, and last_gnt = 2, and clear all pipeline valid bits.
REQ-027 SHALL discard reads in flight when Reset is asserted mid-operation; no rd_valid is produced for them after Reset deasserts.
REQ-028 SHALL accept requests in the first cycle after Reset deasserts, with requester 0 as first-priority candidate.

Configuration
REQ-029 SHALL use macro SPRITE_ARB_ROUND_ROBIN_EN to select the arbitration policy.
REQ-030 SHALL, when SPRITE_ARB_ROUND_ROBIN_EN is defined, search for a grant starting at (last_gnt+1) mod 3 and wrapping to index 0 after index 2.
REQ-031 SHALL, when SPRITE_ARB_ROUND_ROBIN_EN is undefined, use fixed priority 0 > 1 > 2; last_gnt is still maintained but has no effect on selection.

Verification
REQ-032 Single request, ROM_LAT=1: req=001, addr0=0x00040 for 1 cycle -> gnt=001 and rom_addr=0x00040 in that cycle; rd_valid=001 with rd_data=ROM[0x40] exactly 1 cycle later.
REQ-033 RR contention (macro defined): req=111 held for 6 cycles after reset -> gnt sequence 001,010,100,001,010,100; rd_valid follows the same sequence delayed by ROM_LAT.
REQ-034 Fixed priority (macro undefined): req=110 held for 3 cycles, then req=111 -> gnt=010,010,010 then 001.
REQ-035 Pipeline, ROM_LAT=3: grants to 0,1,2 on consecutive cycles -> rd_valid=001,010,100 on cycles +3,+4,+5, each with its matching ROM data.
REQ-036 Reset mid-flight, ROM_LAT=3: grant to 1 at cycle t, Reset high at t+1 -> rd_valid stays 000 through t+6; first request after reset is granted per REQ-028.
REQ-037 Idle: req=000 for 10 cycles -> gnt=000, rom_rd=0, rom_addr=0, rd_valid=000 throughout, and last_gnt unchanged.
